// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: holds a 16-bit word and walks the select of an external
// 16:1 mux across it. The mux output comes back as the serial bit, and every
// bit uses a valid/ready handshake.
module mux_scan_sequencer #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned LAST_SEL  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mux_in,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        ser_bit,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST      = 4'(LAST_SEL);
  localparam logic [3:0] START_SEL = MSB_FIRST ? LAST : 4'd0;
  localparam logic [3:0] END_SEL   = MSB_FIRST ? 4'd0 : LAST;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] hold;
  logic        load;
  logic        hs;
  logic        at_end;

  assign load   = (state == IDLE) && in_valid;
  assign hs     = (state == SEND) && ser_ready;
  assign at_end = (sel == END_SEL);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Hold register and select counter; sel saturates at the end index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
      sel  <= '0;
    end else if (load) begin
      hold <= in_data;
      sel  <= START_SEL;
    end else if (hs && !at_end) begin
      sel <= MSB_FIRST ? sel - 4'd1 : sel + 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SEND;
      SEND:    if (hs && at_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; in_ready is also gated by rst_n so it stays low throughout reset
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: in_ready = rst_n;
      SEND: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign mux_in  = hold;
  assign ser_bit = mux_out;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: four instances (ascending/15, descending/15,
// ascending/0, descending/0). All four share the same stimulus, and each
// instance is paired with its own behavioural 16:1 mux.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        ser_ready;

  logic        a_in_ready, a_mux_out, a_ser_bit, a_ser_valid, a_busy, a_done;
  logic [15:0] a_mux_in;
  logic [3:0]  a_sel;
  logic        b_in_ready, b_mux_out, b_ser_bit, b_ser_valid, b_busy, b_done;
  logic [15:0] b_mux_in;
  logic [3:0]  b_sel;
  logic        c_in_ready, c_mux_out, c_ser_bit, c_ser_valid, c_busy, c_done;
  logic [15:0] c_mux_in;
  logic [3:0]  c_sel;
  logic        d_in_ready, d_mux_out, d_ser_bit, d_ser_valid, d_busy, d_done;
  logic [15:0] d_mux_in;
  logic [3:0]  d_sel;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // Downstream 16:1 muxes
  assign a_mux_out = a_mux_in[a_sel];
  assign b_mux_out = b_mux_in[b_sel];
  assign c_mux_out = c_mux_in[c_sel];
  assign d_mux_out = d_mux_in[d_sel];

  mux_scan_sequencer #(.MSB_FIRST(1'b0), .LAST_SEL(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .mux_in(a_mux_in), .sel(a_sel), .mux_out(a_mux_out),
    .ser_bit(a_ser_bit), .ser_valid(a_ser_valid), .ser_ready(ser_ready),
    .busy(a_busy), .done(a_done));

  mux_scan_sequencer #(.MSB_FIRST(1'b1), .LAST_SEL(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .mux_in(b_mux_in), .sel(b_sel), .mux_out(b_mux_out),
    .ser_bit(b_ser_bit), .ser_valid(b_ser_valid), .ser_ready(ser_ready),
    .busy(b_busy), .done(b_done));

  mux_scan_sequencer #(.MSB_FIRST(1'b0), .LAST_SEL(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(c_in_ready), .mux_in(c_mux_in), .sel(c_sel), .mux_out(c_mux_out),
    .ser_bit(c_ser_bit), .ser_valid(c_ser_valid), .ser_ready(ser_ready),
    .busy(c_busy), .done(c_done));

  mux_scan_sequencer #(.MSB_FIRST(1'b1), .LAST_SEL(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(d_in_ready), .mux_in(d_mux_in), .sel(d_sel), .mux_out(d_mux_out),
    .ser_bit(d_ser_bit), .ser_valid(d_ser_valid), .ser_ready(ser_ready),
    .busy(d_busy), .done(d_done));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Leaves the bench at a falling edge with rst_n still low, after two reset edges
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; ser_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
  endtask

  int unsigned seq_a [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

  initial begin
    logic [15:0] w;
    int unsigned k;
    int unsigned cyc;
    logic        rdy;

    // Reset state
    do_reset();
    #1;
    check_val("rst_in_ready", a_in_ready, 0);
    check_val("rst_sel", a_sel, 0);
    check_val("rst_mux_in", a_mux_in, 16'h0000);
    check_val("rst_ser_valid", a_ser_valid, 0);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_done", a_done, 0);

    // Ascending scan of A5C3, ser_ready tied high
    rst_n = 1'b1; in_data = 16'hA5C3; in_valid = 1'b1; ser_ready = 1'b1;
    #1 check_val("first_in_ready", a_in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_val("asc_sel", a_sel, i);
      check_val("asc_bit", a_ser_bit, seq_a[i]);
      check_val("asc_valid", a_ser_valid, 1);
      check_val("asc_busy", a_busy, 1);
      check_val("asc_in_ready", a_in_ready, 0);
      @(negedge clk);
    end
    #1;
    check_val("asc_done", a_done, 1);
    check_val("asc_done_busy", a_busy, 0);
    check_val("asc_done_valid", a_ser_valid, 0);
    check_val("asc_done_in_ready", a_in_ready, 0);
    check_val("asc_done_sel", a_sel, 15);
    @(negedge clk);
    #1;
    check_val("asc_done_clr", a_done, 0);
    check_val("asc_idle_ready", a_in_ready, 1);

    // Descending scan of 8001
    do_reset();
    rst_n = 1'b1; in_data = 16'h8001; in_valid = 1'b1; ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_val("desc_sel", b_sel, 15 - i);
      check_val("desc_bit", b_ser_bit, (i == 0 || i == 15) ? 1 : 0);
      check_val("desc_valid", b_ser_valid, 1);
      @(negedge clk);
    end
    #1;
    check_val("desc_done", b_done, 1);
    check_val("desc_done_sel", b_sel, 0);

    // Stalls with ser_ready pattern 1,0,0,1
    do_reset();
    w = 16'h3C96;
    rst_n = 1'b1; in_data = w; in_valid = 1'b1; ser_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0; cyc = 0;
    while (k < 16 && cyc < 80) begin
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      ser_ready = rdy;
      #1;
      check_val("stall_sel", a_sel, k);
      check_val("stall_bit", a_ser_bit, w[k]);
      check_val("stall_valid", a_ser_valid, 1);
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    check_val("stall_delivered", k, 16);
    #1 check_val("stall_done", a_done, 1);

    // in_valid held high: back-to-back words, 2-cycle gap
    do_reset();
    rst_n = 1'b1; in_data = 16'h1234; in_valid = 1'b1; ser_ready = 1'b1;
    @(negedge clk);
    in_data = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_val("b2b_in_ready", a_in_ready, 0);
      check_val("b2b_hold", a_mux_in, 16'h1234);
      check_val("b2b_sel", a_sel, i);
      @(negedge clk);
    end
    #1;
    check_val("b2b_done", a_done, 1);
    check_val("b2b_done_in_ready", a_in_ready, 0);
    @(negedge clk);
    #1;
    check_val("b2b_idle_ready", a_in_ready, 1);
    check_val("b2b_idle_hold", a_mux_in, 16'h1234);
    check_val("b2b_idle_busy", a_busy, 0);
    @(negedge clk);
    #1;
    check_val("b2b_second_busy", a_busy, 1);
    check_val("b2b_second_sel", a_sel, 0);
    check_val("b2b_second_hold", a_mux_in, 16'hBEEF);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in the middle of a word, after the 5th handshake
    do_reset();
    rst_n = 1'b1; in_data = 16'hFFFF; in_valid = 1'b1; ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 check_val("mid_sel5", a_sel, 5);
    rst_n = 1'b0;
    #1 check_val("mid_rst_in_ready", a_in_ready, 0);
    @(negedge clk);
    #1;
    check_val("mid_sel", a_sel, 0);
    check_val("mid_valid", a_ser_valid, 0);
    check_val("mid_busy", a_busy, 0);
    check_val("mid_done", a_done, 0);
    check_val("mid_hold", a_mux_in, 16'h0000);
    check_val("mid_in_ready_rst", a_in_ready, 0);
    rst_n = 1'b1;
    #1 check_val("mid_in_ready_rel", a_in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val("mid_no_done", a_done, 0);
      check_val("mid_no_valid", a_ser_valid, 0);
    end

    // LAST_SEL=0, both directions
    do_reset();
    rst_n = 1'b1; in_data = 16'h0001; in_valid = 1'b1; ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("one_asc_sel", c_sel, 0);
    check_val("one_asc_bit", c_ser_bit, 1);
    check_val("one_asc_valid", c_ser_valid, 1);
    check_val("one_desc_sel", d_sel, 0);
    check_val("one_desc_bit", d_ser_bit, 1);
    check_val("one_desc_valid", d_ser_valid, 1);
    @(negedge clk);
    #1;
    check_val("one_asc_done", c_done, 1);
    check_val("one_asc_done_valid", c_ser_valid, 0);
    check_val("one_desc_done", d_done, 1);
    check_val("one_desc_done_sel", d_sel, 0);
    @(negedge clk);
    #1;
    check_val("one_asc_done_clr", c_done, 0);
    check_val("one_asc_idle_ready", c_in_ready, 1);
    check_val("one_desc_idle_ready", d_in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0: 0 = scan sel ascending from 0, 1 = descending from LAST_SEL.
REQ-002 SHALL have parameter LAST_SEL, default 15, legal range 0..15: highest select index scanned, so a word carries LAST_SEL+1 bits.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_data, input, 16: parallel word offered for serialization.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: sequencer accepts a word this cycle.
REQ-008 SHALL have port mux_in, output, 16: held word, driven to the downstream 16:1 mux data input.
REQ-009 SHALL have port sel, output, 4: current select, driven to the downstream 16:1 mux select.
REQ-010 SHALL have port mux_out, input, 1: bit returned by the downstream 16:1 mux.
REQ-011 SHALL have port ser_bit, output, 1: serial bit, equal to mux_out.
REQ-012 SHALL have port ser_valid, output, 1: ser_bit valid.
REQ-013 SHALL have port ser_ready, input, 1: consumer accepts ser_bit.
REQ-014 SHALL have port busy, output, 1: high while a word is being scanned.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the last bit of a word is accepted.

Function
REQ-016 SHALL implement an FSM with states IDLE, SEND and DONE.
REQ-017 In IDLE, SHALL drive in_ready=1, ser_valid=0 and busy=0.
REQ-018 In IDLE, when in_valid=1, SHALL load in_data into the hold register, load sel with the start index (0, or LAST_SEL if MSB_FIRST=1), and go to SEND.
REQ-019 In SEND, SHALL drive in_ready=0, ser_valid=1 and busy=1, and SHALL ignore in_valid.
REQ-020 SHALL connect ser_bit combinationally from mux_out, with zero cycles of latency between sel and ser_bit.
REQ-021 In SEND, when ser_valid=1 and ser_ready=1 and sel is not the end index, SHALL step sel by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1) at the next edge.
REQ-022 In SEND, when the handshake occurs at the end index (LAST_SEL ascending, 0 descending), SHALL go to DONE and leave sel unchanged.
REQ-023 In SEND, when ser_ready=0, SHALL hold sel, the hold register and ser_valid stable with no timeout.
REQ-024 SHALL keep mux_in equal to the hold register and change it only on a load in IDLE.
REQ-025 In DONE, SHALL drive done=1, busy=0, ser_valid=0 and in_ready=0 for exactly one cycle, then go to IDLE.
REQ-026 SHALL impose a minimum of 2 cycles between the last ser handshake of one word and acceptance of the next word (DONE, then IDLE).
REQ-027 With LAST_SEL=0, SHALL send exactly one bit per word in both scan directions.
REQ-028 SHALL never drive sel outside the range 0..LAST_SEL and SHALL not wrap sel.

Reset
REQ-029 When rst_n=0 at a rising clk edge, SHALL enter IDLE with hold register=16'h0000, sel=0, done=0, ser_valid=0 and busy=0.
REQ-030 While rst_n=0, SHALL drive in_ready=0 regardless of state.
REQ-031 Reset asserted during SEND SHALL abandon the word, with no done pulse and no further ser_valid.
REQ-032 The first word SHALL be acceptable on the first edge after rst_n returns to 1.

Verification
REQ-033 Scenario: MSB_FIRST=0, LAST_SEL=15, in_data=16'hA5C3, ser_ready tied 1 -> ser_bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 consecutive cycles; done pulses on the cycle after the 16th handshake.
REQ-034 Scenario: MSB_FIRST=1, in_data=16'h8001 -> first bit 1 with sel=15, then 14 zeros, last bit 1 with sel=0.
REQ-035 Scenario: ser_ready toggled 1,0,0,1,... -> sel and ser_bit stay constant through the stalls; all 16 bits are delivered once, in order.
REQ-036 Scenario: in_valid held high continuously -> second word accepted exactly 2 cycles after the first word's last handshake; in_ready=0 throughout SEND.
REQ-037 Scenario: rst_n pulled low for 1 cycle after the 5th handshake -> next cycle shows sel=0, ser_valid=0, no done pulse, in_ready=0 during reset and 1 after release.
REQ-038 Scenario: LAST_SEL=0, in_data=16'h0001 -> one bit, value 1, sel=0, then done.
